// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default sizing for the register-file write-port controller.
package regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NREG_DEF         = 8;
    localparam int AW_DEF           = 3;
    localparam int DW_DEF           = 8;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_W         = 4;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive cycles the debug port has lost arbitration.
module starve_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != LIM) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIM);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates CPU and debug writes onto the register-file write port and runs
// the one-register-per-cycle clear sequence.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NREG         = NREG_DEF,
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          A_VALID,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_DATA,
    output logic          A_READY,
    input  logic          B_VALID,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_DATA,
    output logic          B_READY,
    input  logic          CLR_REQ,
    output logic          CLR_BUSY,
    output logic          CLR_DONE,
    output logic          RF_WRITE,
    output logic [AW-1:0] RF_ADDR,
    output logic [DW-1:0] RF_DATA
);

    // One extra index bit lets the sequence spend a drain cycle at NREG
    // before DONE, after the last zero write is on the port.
    localparam int IW = AW + 1;
    localparam logic [IW-1:0] CLR_END = IW'(NREG);

    state_t        state, state_nxt;
    logic [IW-1:0] clr_idx, clr_idx_nxt;
    logic          write_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] data_nxt;
    logic          busy_nxt, done_nxt;
    logic          arb_en, grant_a, grant_b, at_limit;

    assign arb_en  = RESET && (state == IDLE) && !CLR_REQ;
    assign grant_b = arb_en && B_VALID && (!A_VALID || at_limit);
    assign grant_a = arb_en && A_VALID && !grant_b;
    assign A_READY = grant_a;
    assign B_READY = grant_b;

    starve_counter #(
        .W     (STARVE_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (CLOCK),
        .rst_n    (RESET),
        .inc      (grant_a && B_VALID),
        .clr      (grant_b || !B_VALID),
        .at_limit (at_limit)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        write_nxt   = 1'b0;
        addr_nxt    = RF_ADDR;
        data_nxt    = RF_DATA;
        busy_nxt    = CLR_BUSY;
        done_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (CLR_REQ) begin
                    state_nxt   = CLEAR;
                    clr_idx_nxt = '0;
                    busy_nxt    = 1'b1;
                end else if (grant_a) begin
                    write_nxt = 1'b1;
                    addr_nxt  = A_ADDR;
                    data_nxt  = A_DATA;
                end else if (grant_b) begin
                    write_nxt = 1'b1;
                    addr_nxt  = B_ADDR;
                    data_nxt  = B_DATA;
                end
            end
            CLEAR: begin
                if (clr_idx == CLR_END) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    write_nxt   = 1'b1;
                    addr_nxt    = clr_idx[AW-1:0];
                    data_nxt    = '0;
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            RF_WRITE <= 1'b0;
            RF_ADDR  <= '0;
            RF_DATA  <= '0;
            CLR_BUSY <= 1'b0;
            CLR_DONE <= 1'b0;
        end else begin
            RF_WRITE <= write_nxt;
            RF_ADDR  <= addr_nxt;
            RF_DATA  <= data_nxt;
            CLR_BUSY <= busy_nxt;
            CLR_DONE <= done_nxt;
        end
    end

endmodule
